fifo_rr_sched: RTL and testbench

- Round-robin scheduler that drains N first-word-fall-through FIFOs (fifo_cc instances, FWFT=1, FLEV=0) into one shared downstream ready/valid stream.
- Owns the rd_en of every FIFO and pops at most one FIFO per cycle.
- Holds a grant for up to BURST words, then rotates priority.
- Output is a one-entry registered slot, so the FIFO outputs never drive the downstream data path combinationally.

---
 rtl/fifo_rr_sched.sv | 107 ++++++++++
 tb/tb_fifo_rr_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_sched.sv
// Round-robin scheduler draining N FWFT FIFOs into one registered ready/valid slot.
// Each grant holds for up to BURST pops, then priority rotates past the served source.
module fifo_rr_sched #(
    parameter int T     = 64,
    parameter int N     = 4,
    parameter int NW    = 2,
    parameter int BURST = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [N*T-1:0]   fifo_dout,
    input  logic [N-1:0]     fifo_empty,
    output logic [N-1:0]     fifo_rd_en,
    output logic [T-1:0]     m_data,
    output logic [NW-1:0]    m_src,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [N-1:0]     grant
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [NW-1:0]   ptr;
    logic [NW-1:0]   gidx;
    logic [CW-1:0]   cnt;
    logic [NW-1:0]   sel;
    logic [NW-1:0]   idx;
    logic            found;
    logic            slot_free;
    logic            pop;
    logic            last_pop;
    logic [T-1:0]    head_p0;

    // Explicit compare keeps the wrap correct when N is not a power of two.
    function automatic logic [NW-1:0] wrap_inc(input logic [NW-1:0] v);
        return (v == NW'(N - 1)) ? '0 : v + NW'(1);
    endfunction

    function automatic logic [N-1:0] onehot(input logic [NW-1:0] v);
        return N'(1) << v;
    endfunction

    always_comb begin
        found = 1'b0;
        sel   = ptr;
        idx   = ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && !fifo_empty[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
            idx = wrap_inc(idx);
        end
    end

    assign slot_free  = !m_valid || m_ready;
    assign pop        = !srst && (state == GRANT) && !fifo_empty[gidx] && slot_free;
    assign last_pop   = pop && (cnt == CW'(BURST - 1));
    assign fifo_rd_en = pop ? onehot(gidx) : '0;
    assign head_p0    = fifo_dout[gidx*T +: T];

    // Slot stage: the popped head word is registered before reaching the output.
    always_ff @(posedge clk) begin
        if (srst) begin
            state   <= IDLE;
            ptr     <= '0;
            gidx    <= '0;
            cnt     <= '0;
            grant   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_src   <= '0;
        end else begin
            if (pop) begin
                m_data  <= head_p0;
                m_src   <= gidx;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        state <= GRANT;
                        gidx  <= sel;
                        grant <= onehot(sel);
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (fifo_empty[gidx] || last_pop) begin
                        state <= IDLE;
                        ptr   <= wrap_inc(gidx);
                        grant <= '0;
                    end else if (pop) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Bench for fifo_rr_sched: queue-backed FIFO models, cycle-exact directed tables and
// sequences, then randomized traffic checked by a per-source scoreboard and grant rules.
module tb_fifo_rr_sched;

    localparam int T     = 64;
    localparam int N     = 4;
    localparam int NW    = 2;
    localparam int BURST = 2;
    localparam int CW    = 3;

    logic             clk;
    logic             srst;
    logic [N*T-1:0]   fifo_dout;
    logic [N-1:0]     fifo_empty;
    logic [N-1:0]     fifo_rd_en;
    logic [T-1:0]     m_data;
    logic [NW-1:0]    m_src;
    logic             m_valid;
    logic             m_ready;
    logic [N-1:0]     grant;

    fifo_rr_sched #(.T(T), .N(N), .NW(NW), .BURST(BURST), .CW(CW)) dut (
        .clk        (clk),
        .srst       (srst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_src      (m_src),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .grant      (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       srst;
        logic       rdy;
        logic [3:0] grant;
        logic [3:0] rd;
        logic       mv;
        logic [1:0] src;
        int         widx;
    } vec_t;

    vec_t        tbl[$];
    logic [63:0] fifo_q[N][$];
    logic [63:0] exp_q[N][$];
    logic [N-1:0] rd_s;
    int checks = 0;
    int errors = 0;

    function automatic logic [63:0] mkword(input int s, input int k);
        return 64'hA5A5_0000_0000_0000 | 64'(s << 8) | 64'(k);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int s, input logic [63:0] w);
        fifo_q[s].push_back(w);
        exp_q[s].push_back(w);
    endtask

    task automatic add(input logic r, input logic y, input logic [3:0] g, input logic [3:0] d,
                       input logic v, input logic [1:0] s, input int k);
        vec_t e;
        e.srst = r; e.rdy = y; e.grant = g; e.rd = d; e.mv = v; e.src = s; e.widx = k;
        tbl.push_back(e);
    endtask

    // Drive inputs away from the active edge, then sample outputs after settling.
    task automatic cycle_begin(input logic r, input logic y);
        @(negedge clk);
        srst    = r;
        m_ready = y;
        for (int i = 0; i < N; i++) begin
            fifo_empty[i] = (fifo_q[i].size() == 0);
            fifo_dout[i*T +: T] = (fifo_q[i].size() == 0) ? '0 : fifo_q[i][0];
        end
        #1;
        rd_s = fifo_rd_en;
    endtask

    task automatic cycle_end();
        @(posedge clk);
        for (int i = 0; i < N; i++)
            if (rd_s[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
    endtask

    task automatic expect_cycle(input string name, input logic r, input logic y,
                                input logic [3:0] g, input logic [3:0] d, input logic v,
                                input logic [1:0] s, input logic [63:0] w);
        cycle_begin(r, y);
        chk({name, ".grant"}, 64'(grant), 64'(g));
        chk({name, ".rd_en"}, 64'(fifo_rd_en), 64'(d));
        chk({name, ".m_valid"}, 64'(m_valid), 64'(v));
        if (v) begin
            chk({name, ".m_src"}, 64'(m_src), 64'(s));
            chk({name, ".m_data"}, m_data, w);
        end
        cycle_end();
    endtask

    logic        prev_stall;
    logic [63:0] prev_data;
    logic [1:0]  prev_src;
    int          burst_n;
    bit          drained;

    initial begin
        srst = 1'b1;
        m_ready = 1'b1;
        fifo_empty = '1;
        fifo_dout = '0;
        rd_s = '0;

        // Reset with every FIFO loaded, then a BURST=2 round-robin drain of 3 words each.
        for (int s = 0; s < N; s++)
            for (int k = 0; k < 3; k++) push(s, mkword(s, k));
        cycle_begin(1'b1, 1'b1);
        cycle_end();

        add(1,1,4'b0000,4'b0000,0,0,0);
        add(1,1,4'b0000,4'b0000,0,0,0);
        add(0,1,4'b0000,4'b0000,0,0,0);
        add(0,1,4'b0001,4'b0001,0,0,0);
        add(0,1,4'b0001,4'b0001,1,0,0);
        add(0,1,4'b0000,4'b0000,1,0,1);
        add(0,1,4'b0010,4'b0010,0,0,0);
        add(0,1,4'b0010,4'b0010,1,1,0);
        add(0,1,4'b0000,4'b0000,1,1,1);
        add(0,1,4'b0100,4'b0100,0,0,0);
        add(0,1,4'b0100,4'b0100,1,2,0);
        add(0,1,4'b0000,4'b0000,1,2,1);
        add(0,1,4'b1000,4'b1000,0,0,0);
        add(0,1,4'b1000,4'b1000,1,3,0);
        add(0,1,4'b0000,4'b0000,1,3,1);
        add(0,1,4'b0001,4'b0001,0,0,0);
        add(0,1,4'b0001,4'b0000,1,0,2);
        add(0,1,4'b0000,4'b0000,0,0,0);
        add(0,1,4'b0010,4'b0010,0,0,0);
        add(0,1,4'b0010,4'b0000,1,1,2);
        add(0,1,4'b0000,4'b0000,0,0,0);
        add(0,1,4'b0100,4'b0100,0,0,0);
        add(0,1,4'b0100,4'b0000,1,2,2);
        add(0,1,4'b0000,4'b0000,0,0,0);
        add(0,1,4'b1000,4'b1000,0,0,0);
        add(0,1,4'b1000,4'b0000,1,3,2);
        add(0,1,4'b0000,4'b0000,0,0,0);

        for (int i = 0; i < tbl.size(); i++)
            expect_cycle($sformatf("rr[%0d]", i), tbl[i].srst, tbl[i].rdy, tbl[i].grant,
                         tbl[i].rd, tbl[i].mv, tbl[i].src, mkword(int'(tbl[i].src), tbl[i].widx));

        // Single source: FIFO2 only; burst completes after two, third word leaves by early release.
        push(2, 64'h11); push(2, 64'h22); push(2, 64'h33);
        expect_cycle("ss0", 0,1,4'b0000,4'b0000,0,0,0);
        expect_cycle("ss1", 0,1,4'b0100,4'b0100,0,0,0);
        expect_cycle("ss2", 0,1,4'b0100,4'b0100,1,2,64'h11);
        expect_cycle("ss3", 0,1,4'b0000,4'b0000,1,2,64'h22);
        expect_cycle("ss4", 0,1,4'b0100,4'b0100,0,0,0);
        expect_cycle("ss5", 0,1,4'b0100,4'b0000,1,2,64'h33);
        expect_cycle("ss6", 0,1,4'b0000,4'b0000,0,0,0);

        // Pointer now 3: FIFO3 wins over FIFO1, then the search wraps and skips 0.
        push(1, 64'hB1); push(3, 64'hB3);
        expect_cycle("wr0", 0,1,4'b0000,4'b0000,0,0,0);
        expect_cycle("wr1", 0,1,4'b1000,4'b1000,0,0,0);
        expect_cycle("wr2", 0,1,4'b1000,4'b0000,1,3,64'hB3);
        expect_cycle("wr3", 0,1,4'b0000,4'b0000,0,0,0);
        expect_cycle("wr4", 0,1,4'b0010,4'b0010,0,0,0);
        expect_cycle("wr5", 0,1,4'b0010,4'b0000,1,1,64'hB1);
        expect_cycle("wr6", 0,1,4'b0000,4'b0000,0,0,0);

        // Pointer now 2: FIFO2 must beat FIFO1.
        push(1, 64'hC1); push(2, 64'hC2);
        expect_cycle("pt0", 0,1,4'b0000,4'b0000,0,0,0);
        expect_cycle("pt1", 0,1,4'b0100,4'b0100,0,0,0);
        expect_cycle("pt2", 0,1,4'b0100,4'b0000,1,2,64'hC2);
        expect_cycle("pt3", 0,1,4'b0000,4'b0000,0,0,0);
        expect_cycle("pt4", 0,1,4'b0010,4'b0010,0,0,0);
        expect_cycle("pt5", 0,1,4'b0010,4'b0000,1,1,64'hC1);
        expect_cycle("pt6", 0,1,4'b0000,4'b0000,0,0,0);

        // Backpressure for 5 cycles after the first pop of a burst.
        expect_cycle("bp_rst", 1,1,4'b0000,4'b0000,0,0,0);
        push(0, 64'hA1); push(0, 64'hA2); push(0, 64'hA3);
        expect_cycle("bp0", 0,1,4'b0000,4'b0000,0,0,0);
        expect_cycle("bp1", 0,1,4'b0001,4'b0001,0,0,0);
        for (int i = 0; i < 5; i++)
            expect_cycle($sformatf("bp_stall%0d", i), 0,0,4'b0001,4'b0000,1,0,64'hA1);
        expect_cycle("bp7", 0,1,4'b0001,4'b0001,1,0,64'hA1);
        expect_cycle("bp8", 0,1,4'b0000,4'b0000,1,0,64'hA2);
        expect_cycle("bp9", 0,1,4'b0001,4'b0001,0,0,0);
        expect_cycle("bp10",0,1,4'b0001,4'b0000,1,0,64'hA3);
        expect_cycle("bp11",0,1,4'b0000,4'b0000,0,0,0);

        // Reset mid-burst with a word in the slot; FIFO0 arrival proves ptr returned to 0.
        push(2, 64'hD0); push(2, 64'hD1); push(2, 64'hD2);
        expect_cycle("rm0", 0,1,4'b0000,4'b0000,0,0,0);
        expect_cycle("rm1", 0,1,4'b0100,4'b0100,0,0,0);
        expect_cycle("rm2", 1,1,4'b0100,4'b0000,1,2,64'hD0);
        push(0, 64'hE0);
        expect_cycle("rm3", 0,1,4'b0000,4'b0000,0,0,0);
        expect_cycle("rm4", 0,1,4'b0001,4'b0001,0,0,0);
        expect_cycle("rm5", 0,1,4'b0001,4'b0000,1,0,64'hE0);
        expect_cycle("rm6", 0,1,4'b0000,4'b0000,0,0,0);
        expect_cycle("rm7", 0,1,4'b0100,4'b0100,0,0,0);
        expect_cycle("rm8", 0,1,4'b0100,4'b0100,1,2,64'hD1);
        expect_cycle("rm9", 0,1,4'b0000,4'b0000,1,2,64'hD2);
        expect_cycle("rm10",0,1,4'b0000,4'b0000,0,0,0);

        // Randomized traffic against the per-source scoreboard and grant rules.
        for (int s = 0; s < N; s++) exp_q[s].delete();
        prev_stall = 1'b0;
        prev_data = '0;
        prev_src = '0;
        burst_n = 0;
        drained = 1'b0;
        for (int cyc = 0; cyc < 3400 && !drained; cyc++) begin
            logic rdy;
            if (cyc < 3000) begin
                for (int s = 0; s < N; s++)
                    if ($urandom_range(0, 3) == 0 && fifo_q[s].size() < 8)
                        push(s, {$urandom, $urandom});
                rdy = ($urandom_range(0, 9) < 7);
            end else begin
                rdy = 1'b1;
            end
            cycle_begin(1'b0, rdy);

            chk("rnd.rd_onehot", 64'($countones(rd_s) <= 1), 64'd1);
            chk("rnd.grant_onehot", 64'($countones(grant) <= 1), 64'd1);
            if (rd_s != '0) begin
                chk("rnd.rd_matches_grant", 64'(rd_s), 64'(grant));
                chk("rnd.rd_when_nonempty", 64'(rd_s & fifo_empty), 64'd0);
                chk("rnd.rd_with_slot_free", 64'(m_valid && !m_ready), 64'd0);
            end
            if (grant == '0) burst_n = 0;
            else if (rd_s != '0) begin
                burst_n++;
                chk("rnd.burst_len", 64'(burst_n <= BURST), 64'd1);
            end
            if (prev_stall) begin
                chk("rnd.stall_valid", 64'(m_valid), 64'd1);
                chk("rnd.stall_data", m_data, prev_data);
                chk("rnd.stall_src", 64'(m_src), 64'(prev_src));
            end
            if (m_valid && m_ready) begin
                if (exp_q[m_src].size() == 0) begin
                    chk("rnd.unexpected_word", m_data, 64'hDEAD);
                end else begin
                    chk($sformatf("rnd.data_src%0d", m_src), m_data, exp_q[m_src].pop_front());
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            prev_src = m_src;
            if (cyc >= 3000 && !m_valid && grant == '0 && fifo_q[0].size() == 0 &&
                fifo_q[1].size() == 0 && fifo_q[2].size() == 0 && fifo_q[3].size() == 0)
                drained = 1'b1;
            cycle_end();
        end
        chk("rnd.drain_timeout", 64'(drained), 64'd1);
        for (int s = 0; s < N; s++)
            chk($sformatf("rnd.leftover_src%0d", s), 64'(exp_q[s].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
